divider_unit: RTL
=================

DIVIDER_UNIT -- requirements
Module: divider_unit

Interface
REQ-001 The block SHALL have no parameters; DIVop width SHALL be 2 bits, matching `DIV_OP_WIDTH`.
REQ-002 The block SHALL use one clock; reset SHALL be asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 resetn  input  1  asynchronous active-low reset.
REQ-005 div_valid  input  1  request from control unit; held high until div_ready is seen; low in the cycle after div_ready.
REQ-006 DIVop  input  2  operation select: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-007 dividend  input  32  rs1 operand.
REQ-008 divisor  input  32  rs2 operand.
REQ-009 div_ready  output  1  one-cycle completion pulse; div_result is valid in this cycle.
REQ-010 div_result  output  32  quotient or remainder per DIVop, registered.

Function
REQ-011 States SHALL be IDLE, CALC and DONE; the reset state SHALL be IDLE.
REQ-012 IDLE with div_valid=1 SHALL latch DIVop, the operand magnitudes and the sign flags, then go to CALC, or go straight to DONE for the special cases.
REQ-013 Signed ops (DIV, REM) SHALL divide absolute values; unsigned ops SHALL use the operands raw.
- Quotient sign = sign(dividend) XOR sign(divisor).
- Remainder sign = sign(dividend).
REQ-014 CALC SHALL do restoring radix-2 division, one quotient bit per cycle, MSB first.
- 33-bit partial remainder, 5-bit iteration counter.
- Exactly 32 cycles, then DONE.
REQ-015 Operand inputs SHALL be ignored outside IDLE; mid-operation changes SHALL not affect the result.
REQ-016 DONE SHALL assert div_ready=1 for exactly one cycle with div_result final, then return to IDLE unconditionally.
REQ-017 Latency (div_valid first high in IDLE at cycle t):
- Normal case: div_ready high in cycle t+33.
- Special cases: div_ready high in cycle t+1.
REQ-018 Divide by zero (divisor=0) SHALL take the special path.
- DIV/DIVU: result 0xFFFFFFFF.
- REM/REMU: result = dividend.
REQ-019 Signed overflow (DIV/REM, dividend=0x80000000, divisor=0xFFFFFFFF) SHALL take the special path.
- DIV: result 0x80000000.
- REM: result 0x00000000.
REQ-020 div_result SHALL hold its last value from DONE until the next DONE.
REQ-021 div_ready SHALL be 0 in IDLE and CALC.
REQ-022 div_valid low in IDLE SHALL leave all state unchanged.
REQ-023 The block SHALL not start a new operation in the DONE cycle; a request held over into IDLE starts normally.
REQ-024 Signed negation of 0x80000000 SHALL yield magnitude 0x80000000, interpreted as unsigned.

Reset
REQ-025 resetn=0 SHALL immediately, without waiting for clk, force all of the following:
- state=IDLE, div_ready=0, div_result=0x00000000;
- iteration counter=0, partial remainder=0, latched op/sign flags=0.
REQ-026 Reset asserted during CALC or DONE SHALL abort the operation; no div_ready pulse SHALL follow reset release.
REQ-027 After resetn deasserts, the first rising edge with div_valid=1 SHALL start an operation normally.

Verification
REQ-028 DIVU, dividend=100, divisor=7 -> div_ready at t+33, div_result=14; REMU with the same operands -> 2.
REQ-029 DIV, dividend=0xFFFFFFF9 (-7), divisor=2 -> 0xFFFFFFFD (-3); REM with the same operands -> 0xFFFFFFFF (-1).
REQ-030 DIVU 0x12345678/0 -> 0xFFFFFFFF at t+1; REM 0x12345678/0 -> 0x12345678 at t+1.
REQ-031 DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at t+1; REM with the same operands -> 0 at t+1.
REQ-032 Start DIVU 0xFFFFFFFF/1, toggle the operands during CALC, then pulse resetn low at cycle t+10 -> div_ready=0 and div_result=0 immediately; no pulse thereafter; next request (DIVU 0xFFFFFFFF/1) -> 0xFFFFFFFF.
REQ-033 Back-to-back requests (div_valid re-raised the cycle after div_ready) -> each result correct; exactly one div_ready pulse per request.

Source files
------------

// File: rtl/divider_unit.sv
// Iterative 32-bit integer divider (DIV/DIVU/REM/REMU) for the execute stage.
// Restoring radix-2, one quotient bit per cycle; divide-by-zero and signed overflow resolve in one cycle.
module divider_unit (
  input  logic        clk,
  input  logic        resetn,
  input  logic        div_valid,
  input  logic [1:0]  DIVop,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        div_ready,
  output logic [31:0] div_result
);

  localparam int DATA_W       = 32;
  localparam int DIV_OP_WIDTH = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [DIV_OP_WIDTH-1:0] op_q, op_d;
  logic                    sa_q, sa_d;
  logic                    sb_q, sb_d;
  logic [DATA_W-1:0]       dvs_q, dvs_d;
  logic [DATA_W-1:0]       quo_q, quo_d;
  logic [DATA_W:0]         rem_q, rem_d;
  logic [4:0]              cnt_q, cnt_d;
  logic                    ready_q, ready_d;
  logic [DATA_W-1:0]       result_q, result_d;

  logic signed [DATA_W-1:0] dvd_s, dvs_s;
  logic                     signed_op, div_zero, sgn_ovf;
  logic [DATA_W:0]          rem_shift, rem_sub, iter_rem;
  logic [DATA_W-1:0]        iter_quo, quo_fin, rem_fin;
  logic                     ge;

  function automatic logic [DATA_W-1:0] neg_if(input logic [DATA_W-1:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

  // 0x80000000 negates to itself, which read as unsigned is the correct magnitude.
  function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] v,
                                                  input logic is_signed);
    logic [DATA_W-1:0] u;
    u = v;
    return (is_signed && (v < 0)) ? (~u + 32'd1) : u;
  endfunction

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    dvs_d    = dvs_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    ready_d  = ready_q;
    result_d = result_q;

    dvd_s     = dividend;
    dvs_s     = divisor;
    signed_op = ~DIVop[0];
    div_zero  = (divisor == 32'd0);
    sgn_ovf   = signed_op && (dividend == 32'h8000_0000) && (divisor == 32'hFFFF_FFFF);

    // Shift in the next dividend bit and trial-subtract; rem_q[32] set would mean the value exceeds any divisor.
    rem_shift = {rem_q[DATA_W-1:0], quo_q[DATA_W-1]};
    ge        = rem_q[DATA_W] | (rem_shift >= {1'b0, dvs_q});
    rem_sub   = rem_shift - {1'b0, dvs_q};
    iter_rem  = ge ? rem_sub : rem_shift;
    iter_quo  = {quo_q[DATA_W-2:0], ge};
    quo_fin   = neg_if(iter_quo, ~op_q[0] & (sa_q ^ sb_q));
    rem_fin   = neg_if(iter_rem[DATA_W-1:0], ~op_q[0] & sa_q);

    case (state_q)
      IDLE: begin
        ready_d = 1'b0;
        if (div_valid) begin
          op_d  = DIVop;
          sa_d  = signed_op & (dvd_s < 0);
          sb_d  = signed_op & (dvs_s < 0);
          dvs_d = magnitude(dvs_s, signed_op);
          quo_d = magnitude(dvd_s, signed_op);
          rem_d = '0;
          cnt_d = '0;
          if (div_zero) begin
            result_d = DIVop[1] ? dividend : 32'hFFFF_FFFF;
            ready_d  = 1'b1;
            state_d  = DONE;
          end else if (sgn_ovf) begin
            result_d = DIVop[1] ? 32'h0000_0000 : 32'h8000_0000;
            ready_d  = 1'b1;
            state_d  = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        rem_d = iter_rem;
        quo_d = iter_quo;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          result_d = op_q[1] ? rem_fin : quo_fin;
          ready_d  = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        ready_d = 1'b0;
        state_d = IDLE;
      end
      default: begin
        ready_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      op_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      dvs_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      dvs_q    <= dvs_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      result_q <= result_d;
    end
  end

  assign div_ready  = ready_q;
  assign div_result = result_q;

endmodule
